// File: rtl/ultrasonic_core.sv
// ultrasonic_core
//   Single-channel HC-SR04-style range core. A software START write fires a
//   registered trigger pulse. The core then times the high width of the echo
//   in clk_i cycles and flags a timeout when the echo never completes.
// Ports
//   clk_i, rst_i          : clock, synchronous active-high reset
//   cs_i, wr_i, rd_i      : slot select, write strobe, read strobe (reads are side-effect free)
//   addr_i, wr_data_i     : register address (bits [1:0] decoded), write data
//   rd_data_o             : combinational read data, 0 when cs_i is low
//   trig_o, echo_i        : sensor trigger out, asynchronous echo in
// Register map
//   0 W CTRL   bit0 START (self-clearing), bit1 CLR (clears done/timeout)
//   0 R STATUS {29'b0, timeout, done, busy}
//   1 R WIDTH  echo-high cycles of the last completed measurement (0 on timeout)
//   2 R COUNT  completed measurements since reset, including timeouts
//   3 R 0
module ultrasonic_core #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TRIG_US     = 10,
  parameter int TIMEOUT_US  = 38000,
  parameter int CNT_W       = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cs_i,
  input  logic        wr_i,
  input  logic        rd_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] rd_data_o,
  output logic        trig_o,
  input  logic        echo_i
);

  localparam int CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int TRIG_CYC   = CYC_PER_US * TRIG_US;
  localparam int TMO_CYC    = CYC_PER_US * TIMEOUT_US;
  localparam int TRIG_W     = $clog2(TRIG_CYC + 1);
  localparam int TMO_W      = $clog2(TMO_CYC + 1);

  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TRIG = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_MEAS = 2'd3;

  logic [1:0]        r_state;
  logic              r_trig;
  logic              r_sync1, r_sync2, r_echo_d;
  logic [TRIG_W-1:0] r_tcnt;
  logic [TMO_W-1:0]  r_tmo;
  logic [CNT_W-1:0]  r_wcnt;
  logic [CNT_W-1:0]  r_width;
  logic [31:0]       r_count;
  logic              r_done, r_timeout;

  logic w_wr_ctrl, w_start, w_clr, w_rise, w_fall, w_busy;
  logic w_unused;

  assign w_wr_ctrl = cs_i & wr_i & (addr_i[1:0] == 2'd0);
  assign w_start   = w_wr_ctrl & wr_data_i[0];
  assign w_clr     = w_wr_ctrl & wr_data_i[1];
  assign w_rise    = r_sync2 & ~r_echo_d;
  assign w_fall    = ~r_sync2 & r_echo_d;
  assign w_busy    = (r_state != S_IDLE);
  assign trig_o    = r_trig;

  // Strobes and address/data bits the register map does not decode.
  assign w_unused  = &{1'b0, rd_i, addr_i[4:2], wr_data_i[31:2]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_trig    <= 1'b0;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_echo_d  <= 1'b0;
      r_tcnt    <= '0;
      r_tmo     <= '0;
      r_wcnt    <= '0;
      r_width   <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_sync1  <= echo_i;
      r_sync2  <= r_sync1;
      r_echo_d <= r_sync2;

      // CLR is applied first; a completion later in this block still wins.
      if (w_clr) begin
        r_done    <= 1'b0;
        r_timeout <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state   <= S_TRIG;
            r_trig    <= 1'b1;
            r_tcnt    <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        S_TRIG: begin
          if (r_tcnt == TRIG_LAST) begin
            r_state <= S_WAIT;
            r_trig  <= 1'b0;
            r_tmo   <= '0;
          end else begin
            r_tcnt <= r_tcnt + TRIG_W'(1);
          end
        end
        default: begin  // S_WAIT, S_MEAS: timeout window is open
          r_tmo <= r_tmo + TMO_W'(1);
          if (r_state == S_MEAS && w_fall) begin
            r_width <= r_wcnt;
            r_done  <= 1'b1;
            r_count <= r_count + 32'd1;
            r_state <= S_IDLE;
          end else if (r_tmo == TMO_LAST) begin
            r_width   <= '0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_count   <= r_count + 32'd1;
            r_state   <= S_IDLE;
          end else if (r_state == S_WAIT) begin
            // The cycle the rise is seen is already an echo-high cycle, so it counts as 1.
            if (w_rise) begin
              r_state <= S_MEAS;
              r_wcnt  <= CNT_W'(1);
            end
          end else if (r_sync2 && (r_wcnt != {CNT_W{1'b1}})) begin
            r_wcnt <= r_wcnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_data_o = 32'd0;
    if (cs_i) begin
      case (addr_i[1:0])
        2'd0:    rd_data_o = {29'd0, r_timeout, r_done, w_busy};
        2'd1:    rd_data_o = 32'(r_width);
        2'd2:    rd_data_o = r_count;
        default: rd_data_o = 32'd0;
      endcase
    end
  end

endmodule
